// File: rtl/load_resp_unit_pkg.sv
// Shared RISC-V load definitions: funct3 encodings and the load-response FSM state type.
package riscv_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } ld_state_t;

endpackage

// File: rtl/load_resp_unit_if.sv
// Bundle of load-issue, data-memory response and writeback signals for load_resp_unit.
interface load_resp_unit_if #(
    parameter int WIDTH = 32
);
    logic             ld_valid;
    logic             ld_ready;
    logic [2:0]       ld_funct3;
    logic [1:0]       ld_offset;
    logic [4:0]       ld_rd;
    logic             dmem_resp_valid;
    logic [WIDTH-1:0] dmem_resp_data;
    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_data;
    logic [4:0]       wb_rd;
    logic             wb_err;
    logic             resp_spurious;

    modport slave (
        input  ld_valid, ld_funct3, ld_offset, ld_rd,
        input  dmem_resp_valid, dmem_resp_data, wb_ready,
        output ld_ready, wb_valid, wb_data, wb_rd, wb_err, resp_spurious
    );

    modport master (
        output ld_valid, ld_funct3, ld_offset, ld_rd,
        output dmem_resp_valid, dmem_resp_data, wb_ready,
        input  ld_ready, wb_valid, wb_data, wb_rd, wb_err, resp_spurious
    );

endinterface

// File: rtl/load_resp_unit_extract.sv
// Combinational load data extraction: shift the addressed lane down, then sign/zero-extend.
module load_extract
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       funct3,
    input  logic [1:0]       offset,
    output logic [WIDTH-1:0] ext_data,
    output logic             err
);

    logic [WIDTH-1:0] s;

    always_comb begin
        s        = data >> {offset, 3'b000};
        ext_data = '0;
        err      = 1'b0;
        case (funct3)
            FUNCT3_LB:  ext_data = {{(WIDTH-8){s[7]}}, s[7:0]};
            FUNCT3_LBU: ext_data = {{(WIDTH-8){1'b0}}, s[7:0]};
            // Offset 3 halves straddle the word; the shift leaves zeros in the upper byte.
            FUNCT3_LH: begin
                ext_data = {{(WIDTH-16){s[15]}}, s[15:0]};
                err      = (offset == 2'd3);
            end
            FUNCT3_LHU: begin
                ext_data = {{(WIDTH-16){1'b0}}, s[15:0]};
                err      = (offset == 2'd3);
            end
            FUNCT3_LW: begin
                ext_data = data;
                err      = (offset != 2'd0);
            end
            default: begin
                ext_data = '0;
                err      = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_resp_unit.sv
// Load-response unit: tracks one outstanding load, extracts the dmem response and holds it for writeback.
module load_resp_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    load_resp_unit_if.slave bus
);

    ld_state_t        state;
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] ext_data;
    logic             ext_err;

    load_extract #(.WIDTH(WIDTH)) u_extract (
        .data     (bus.dmem_resp_data),
        .funct3   (funct3_q),
        .offset   (offset_q),
        .ext_data (ext_data),
        .err      (ext_err)
    );

    assign bus.ld_ready = (state == IDLE) || ((state == HOLD) && bus.wb_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            funct3_q          <= '0;
            offset_q          <= '0;
            rd_q              <= '0;
            bus.wb_valid      <= 1'b0;
            bus.wb_data       <= '0;
            bus.wb_rd         <= '0;
            bus.wb_err        <= 1'b0;
            bus.resp_spurious <= 1'b0;
        end else begin
            bus.resp_spurious <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.dmem_resp_valid) bus.resp_spurious <= 1'b1;
                    if (bus.ld_valid) begin
                        funct3_q <= bus.ld_funct3;
                        offset_q <= bus.ld_offset;
                        rd_q     <= bus.ld_rd;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.dmem_resp_valid) begin
                        bus.wb_valid <= 1'b1;
                        bus.wb_data  <= ext_data;
                        bus.wb_rd    <= rd_q;
                        bus.wb_err   <= ext_err;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.dmem_resp_valid) bus.resp_spurious <= 1'b1;
                    if (bus.wb_ready) begin
                        bus.wb_valid <= 1'b0;
                        if (bus.ld_valid) begin
                            funct3_q <= bus.ld_funct3;
                            offset_q <= bus.ld_offset;
                            rd_q     <= bus.ld_rd;
                            state    <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_resp_unit.sv
// Self-checking bench for load_resp_unit: directed vectors plus randomized loads against a byte-level model.
module tb_load_resp_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    load_resp_unit_if #(.WIDTH(32)) bus();

    load_resp_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
        bus.ld_valid  = 1'b1;
        bus.ld_funct3 = f3;
        bus.ld_offset = off;
        bus.ld_rd     = rd;
        tick();
        bus.ld_valid  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        bus.dmem_resp_valid = 1'b1;
        bus.dmem_resp_data  = d;
        tick();
        bus.dmem_resp_valid = 1'b0;
    endtask

    task automatic retire();
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
    endtask

    // Reference: pick bytes out of the little-endian word and build the value arithmetically.
    function automatic void ref_load(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] off,
                                     output logic [31:0] v, output logic e);
        int unsigned by [4];
        int unsigned o, lo, hi, half;
        for (int i = 0; i < 4; i++) by[i] = 32'(d[8*i +: 8]);
        o    = 32'(off);
        lo   = by[o];
        hi   = (o == 3) ? 0 : by[o + 1];
        half = hi * 256 + lo;
        v    = '0;
        e    = 1'b0;
        case (f3)
            3'b000: v = (lo >= 128) ? lo - 256 : lo;
            3'b100: v = lo;
            3'b001: begin v = (half >= 32768) ? half - 65536 : half; e = (o == 3); end
            3'b101: begin v = half; e = (o == 3); end
            3'b010: begin v = d; e = (o != 0); end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        rst_n               = 1'b0;
        bus.ld_valid        = 1'b0;
        bus.ld_funct3       = '0;
        bus.ld_offset       = '0;
        bus.ld_rd           = '0;
        bus.dmem_resp_valid = 1'b0;
        bus.dmem_resp_data  = '0;
        bus.wb_ready        = 1'b0;
        repeat (2) tick();
        total++;
        if ({bus.ld_ready, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err, bus.resp_spurious}
            !== {1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h rd=%0d e=%b sp=%b want rdy=1 rest 0",
                     bus.ld_ready, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err, bus.resp_spurious);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({bus.ld_ready, bus.wb_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", bus.ld_ready, bus.wb_valid);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] d;
        logic [31:0] v;
        logic        e;
    } vec_t;

    task automatic test_extract();
        vec_t tv [9];
        tv[0] = '{FUNCT3_LB,  2'd2, 32'h1280_FF34, 32'hFFFF_FF80, 1'b0};
        tv[1] = '{FUNCT3_LBU, 2'd2, 32'h1280_FF34, 32'h0000_0080, 1'b0};
        tv[2] = '{FUNCT3_LH,  2'd2, 32'h8001_1234, 32'hFFFF_8001, 1'b0};
        tv[3] = '{FUNCT3_LHU, 2'd0, 32'h8001_1234, 32'h0000_1234, 1'b0};
        tv[4] = '{FUNCT3_LH,  2'd3, 32'h8001_1234, 32'h0000_0080, 1'b1};
        tv[5] = '{FUNCT3_LW,  2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        tv[6] = '{3'b011,     2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tv[7] = '{FUNCT3_LW,  2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        tv[8] = '{FUNCT3_LB,  2'd3, 32'h7F00_0000, 32'h0000_007F, 1'b0};
        for (int i = 0; i < 9; i++) begin
            issue(tv[i].f3, tv[i].off, 5'(i + 1));
            respond(tv[i].d);
            total++;
            if ({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err} !== {1'b1, tv[i].v, 5'(i + 1), tv[i].e}) begin
                bad++;
                $display("FAIL extract[%0d]: got v=%b d=%h rd=%0d e=%b want v=1 d=%h rd=%0d e=%b", i,
                         bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err, tv[i].v, i + 1, tv[i].e);
            end
            retire();
        end
    endtask

    task automatic test_stall();
        issue(FUNCT3_LW, 2'd0, 5'd9);
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({bus.ld_ready, bus.wb_valid} !== 2'b00) begin
                bad++;
                $display("FAIL stall_wait[%0d]: got rdy=%b v=%b want 0 0", c, bus.ld_ready, bus.wb_valid);
            end
            tick();
        end
        respond(32'h0BAD_F00D);
        bus.ld_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({bus.ld_ready, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err}
                !== {1'b0, 1'b1, 32'h0BAD_F00D, 5'd9, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b d=%h rd=%0d e=%b want rdy=0 v=1 d=0badf00d rd=9 e=0",
                         c, bus.ld_ready, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err);
            end
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.wb_ready = 1'b1;
        #1;
        total++;
        if (bus.ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_ready: got rdy=%b want 1", bus.ld_ready);
        end
        tick();
        bus.wb_ready = 1'b0;
        total++;
        if ({bus.ld_ready, bus.wb_valid} !== 2'b10) begin
            bad++;
            $display("FAIL stall_retire: got rdy=%b v=%b want rdy=1 v=0", bus.ld_ready, bus.wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        issue(FUNCT3_LBU, 2'd1, 5'd3);
        respond(32'h0000_AB00);
        bus.wb_ready  = 1'b1;
        bus.ld_valid  = 1'b1;
        bus.ld_funct3 = FUNCT3_LH;
        bus.ld_offset = 2'd0;
        bus.ld_rd     = 5'd4;
        tick();
        bus.wb_ready = 1'b0;
        bus.ld_valid = 1'b0;
        total++;
        if ({bus.ld_ready, bus.wb_valid} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_accept: got rdy=%b v=%b want 0 0", bus.ld_ready, bus.wb_valid);
        end
        respond(32'h1234_F00F);
        total++;
        if ({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err} !== {1'b1, 32'hFFFF_F00F, 5'd4, 1'b0}) begin
            bad++;
            $display("FAIL b2b_result: got v=%b d=%h rd=%0d e=%b want v=1 d=fffff00f rd=4 e=0",
                     bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err);
        end
        retire();
    endtask

    task automatic test_spurious();
        bus.dmem_resp_valid = 1'b1;
        bus.dmem_resp_data  = 32'h5555_AAAA;
        tick();
        bus.dmem_resp_valid = 1'b0;
        total++;
        if ({bus.resp_spurious, bus.wb_valid, bus.ld_ready} !== 3'b101) begin
            bad++;
            $display("FAIL spur_idle: got sp=%b v=%b rdy=%b want 1 0 1", bus.resp_spurious, bus.wb_valid, bus.ld_ready);
        end
        tick();
        total++;
        if (bus.resp_spurious !== 1'b0) begin
            bad++;
            $display("FAIL spur_pulse: got sp=%b want 0", bus.resp_spurious);
        end
        issue(FUNCT3_LB, 2'd0, 5'd7);
        respond(32'h0000_0011);
        respond(32'hFFFF_FFFF);
        total++;
        if ({bus.resp_spurious, bus.wb_valid, bus.wb_data, bus.wb_rd} !== {1'b1, 1'b1, 32'h11, 5'd7}) begin
            bad++;
            $display("FAIL spur_hold: got sp=%b v=%b d=%h rd=%0d want sp=1 v=1 d=00000011 rd=7",
                     bus.resp_spurious, bus.wb_valid, bus.wb_data, bus.wb_rd);
        end
        retire();
    endtask

    task automatic test_reset_mid_wait();
        issue(FUNCT3_LW, 2'd0, 5'd12);
        rst_n = 1'b0;
        #2;
        total++;
        if ({bus.ld_ready, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err, bus.resp_spurious}
            !== {1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_state: got rdy=%b v=%b d=%h rd=%0d e=%b sp=%b want rdy=1 rest 0",
                     bus.ld_ready, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err, bus.resp_spurious);
        end
        rst_n = 1'b1;
        tick();
        respond(32'h1357_9BDF);
        total++;
        if ({bus.resp_spurious, bus.wb_valid, bus.ld_ready} !== 3'b101) begin
            bad++;
            $display("FAIL midreset_late: got sp=%b v=%b rdy=%b want 1 0 1", bus.resp_spurious, bus.wb_valid, bus.ld_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic        pending = 1'b0;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic [31:0] d, ev;
        logic        ee, b2b;
        for (int n = 0; n < 150; n++) begin
            if (!pending) begin
                f3  = 3'($urandom_range(0, 7));
                off = 2'($urandom_range(0, 3));
                rd  = 5'($urandom);
                total++;
                if (bus.ld_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_idle[%0d]: got rdy=%b want 1", n, bus.ld_ready);
                end
                issue(f3, off, rd);
            end
            repeat ($urandom_range(0, 3)) tick();
            total++;
            if ({bus.ld_ready, bus.wb_valid} !== 2'b00) begin
                bad++;
                $display("FAIL rand_wait[%0d]: got rdy=%b v=%b want 0 0", n, bus.ld_ready, bus.wb_valid);
            end
            d = $urandom;
            respond(d);
            ref_load(d, f3, off, ev, ee);
            repeat ($urandom_range(0, 2)) tick();
            total++;
            if ({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err} !== {1'b1, ev, rd, ee}) begin
                bad++;
                $display("FAIL rand_result[%0d]: f3=%0d off=%0d raw=%h got v=%b d=%h rd=%0d e=%b want v=1 d=%h rd=%0d e=%b",
                         n, f3, off, d, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err, ev, rd, ee);
            end
            b2b           = 1'($urandom_range(0, 1));
            bus.wb_ready  = 1'b1;
            bus.ld_valid  = b2b;
            bus.ld_funct3 = 3'($urandom_range(0, 7));
            bus.ld_offset = 2'($urandom_range(0, 3));
            bus.ld_rd     = 5'($urandom);
            f3            = bus.ld_funct3;
            off           = bus.ld_offset;
            rd            = bus.ld_rd;
            tick();
            bus.wb_ready = 1'b0;
            bus.ld_valid = 1'b0;
            total++;
            if ({bus.wb_valid, bus.ld_ready} !== {1'b0, ~b2b}) begin
                bad++;
                $display("FAIL rand_retire[%0d]: got v=%b rdy=%b want v=0 rdy=%b", n, bus.wb_valid, bus.ld_ready, ~b2b);
            end
            pending = b2b;
        end
        if (pending) begin
            respond(32'h0);
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_extract();
        test_stall();
        test_back_to_back();
        test_spurious();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
